// File: rtl/mux_demux_rr_scheduler.sv
// Round-robin scheduler for a shared 4:1 mux -> 1:4 demux channel with bounded bursts.
// One source lane owns the channel per burst; each beat is registered toward its own destination.
module mux_demux_rr_scheduler #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         src_valid,
   output logic [3:0]         src_ready,
   input  logic [4*WIDTH-1:0] src_data,
   input  logic [7:0]         src_dest,
   input  logic [3:0]         src_last,
   output logic [1:0]         mux_sel,
   output logic [1:0]         demux_sel,
   output logic [3:0]         dst_valid,
   input  logic [3:0]         dst_ready,
   output logic [WIDTH-1:0]   dst_data,
   output logic               busy
);

   localparam int unsigned CntW = 5;
   localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e            state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [1:0]        demux_sel_q, demux_sel_d;
   logic [WIDTH-1:0]  dst_data_q, dst_data_d;

   logic              can_load;
   logic              consume;
   logic              xfer;
   logic              own_valid;
   logic              own_last;
   logic [WIDTH-1:0]  own_data;
   logic [1:0]        own_dest;
   logic [1:0]        winner;
   logic              found;
   logic [1:0]        scan_idx;

   // Shared mux: the owner's lane fields.
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      own_dest  = '0;
      for (int i = 0; i < 4; i++) begin
         if (owner_q == 2'(i)) begin
            own_valid = src_valid[i];
            own_last  = src_last[i];
            own_data  = src_data[i*WIDTH +: WIDTH];
            own_dest  = src_dest[2*i +: 2];
         end
      end
   end

   // First valid lane scanning from rr_ptr upward, wrapping.
   always_comb begin
      winner   = rr_ptr_q;
      found    = 1'b0;
      scan_idx = rr_ptr_q;
      for (int k = 0; k < 4; k++) begin
         scan_idx = rr_ptr_q + 2'(k);
         if (!found && src_valid[scan_idx]) begin
            winner = scan_idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      can_load = !out_valid_q || dst_ready[demux_sel_q];
      consume  = out_valid_q && dst_ready[demux_sel_q];
      xfer     = (state_q == StBurst) && own_valid && can_load;

      src_ready = '0;
      if (state_q == StBurst) begin
         src_ready[owner_q] = can_load;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      beat_cnt_d  = beat_cnt_q;
      out_valid_d = out_valid_q && !consume;
      demux_sel_d = demux_sel_q;
      dst_data_d  = dst_data_q;

      case (state_q)
         StIdle: begin
            if (|src_valid) begin
               owner_d    = winner;
               beat_cnt_d = '0;
               state_d    = StBurst;
            end
         end
         StBurst: begin
            if (xfer) begin
               dst_data_d  = own_data;
               demux_sel_d = own_dest;
               out_valid_d = 1'b1;
               beat_cnt_d  = beat_cnt_q + 1'b1;
               if (own_last || beat_cnt_q == CntLast) begin
                  rr_ptr_d = owner_q + 2'd1;
                  state_d  = StIdle;
               end
            end else if (!own_valid) begin
               // Owner went idle: release without a transfer.
               rr_ptr_d = owner_q + 2'd1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         beat_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         demux_sel_q <= '0;
         dst_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         beat_cnt_q  <= beat_cnt_d;
         out_valid_q <= out_valid_d;
         demux_sel_q <= demux_sel_d;
         dst_data_q  <= dst_data_d;
      end
   end

   assign mux_sel   = owner_q;
   assign demux_sel = demux_sel_q;
   assign dst_data  = dst_data_q;
   assign dst_valid = {3'b000, out_valid_q} << demux_sel_q;
   assign busy      = (state_q == StBurst) || out_valid_q;

   a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(src_ready));
   a_valid_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(dst_valid));

endmodule

// File: tb/tb_mux_demux_rr_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle model
// built from the arbitration rules (queues of lane state, modular scans, beat counts).
module tb_mux_demux_rr_scheduler;

   localparam int W  = 16;
   localparam int MB = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [3:0]     src_valid, src_ready, src_last, dst_valid, dst_ready;
   logic [4*W-1:0] src_data;
   logic [7:0]     src_dest;
   logic [1:0]     mux_sel, demux_sel;
   logic [W-1:0]   dst_data;
   logic           busy;

   mux_demux_rr_scheduler #(.WIDTH(W), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst       (rst),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_data  (src_data),
      .src_dest  (src_dest),
      .src_last  (src_last),
      .mux_sel   (mux_sel),
      .demux_sel (demux_sel),
      .dst_valid (dst_valid),
      .dst_ready (dst_ready),
      .dst_data  (dst_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Behavioural model state.
   bit           m_burst;
   int           m_owner, m_ptr, m_beats;
   bit           m_ov;
   logic [W-1:0] m_data;
   int           m_dest;
   int           wait_bursts[4];

   // Directed lane generators.
   int           rem[4];
   bit           lastv[4];
   logic [W-1:0] ldata[4];
   logic [1:0]   ldest[4];
   bit           rand_mode = 1'b0;
   logic [3:0]   acc;
   int           dut_beats[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_burst = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
      m_ov = 0; m_data = '0; m_dest = 0;
      for (int i = 0; i < 4; i++) wait_bursts[i] = 0;
   endtask

   task automatic model_cycle();
      bit         can, consume;
      logic [3:0] e_ready;
      int         l;
      bit         got;
      can     = !m_ov || dst_ready[m_dest];
      consume = m_ov && dst_ready[m_dest];
      e_ready = (m_burst && can) ? 4'(1 << m_owner) : 4'b0;
      chk("src_ready", src_ready, e_ready);
      chk("mux_sel", mux_sel, m_owner);
      chk("demux_sel", demux_sel, m_dest);
      chk("dst_valid", dst_valid, m_ov ? 4'(1 << m_dest) : 4'b0);
      chk("dst_data", dst_data, m_data);
      chk("busy", busy, m_burst || m_ov);
      if (!rst) return;
      if (consume) m_ov = 0;
      if (!m_burst) begin
         if (src_valid != 4'b0) begin
            got = 0;
            for (int k = 0; k < 4; k++) begin
               l = (m_ptr + k) % 4;
               if (!got && src_valid[l]) begin
                  m_owner = l;
                  got     = 1;
               end
            end
            m_beats = 0;
            m_burst = 1;
            for (int i = 0; i < 4; i++) begin
               if (i == m_owner || !src_valid[i]) wait_bursts[i] = 0;
               else begin
                  wait_bursts[i]++;
                  chk("fairness", wait_bursts[i] <= 3, 1);
               end
            end
         end
      end else if (src_valid[m_owner]) begin
         if (can) begin
            m_data  = src_data[m_owner*W +: W];
            m_dest  = int'(src_dest[2*m_owner +: 2]);
            m_ov    = 1;
            m_beats = m_beats + 1;
            if (src_last[m_owner] || m_beats == MB) begin
               m_burst = 0;
               m_ptr   = (m_owner + 1) % 4;
            end
         end
      end else begin
         m_burst = 0;
         m_ptr   = (m_owner + 1) % 4;
      end
   endtask

   task automatic apply_lanes();
      for (int i = 0; i < 4; i++) begin
         src_valid[i]          = rem[i] > 0;
         src_last[i]           = lastv[i];
         src_data[i*W +: W]    = ldata[i];
         src_dest[2*i +: 2]    = ldest[i];
      end
   endtask

   task automatic next_inputs();
      if (!rand_mode) begin
         for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
               rem[i]--;
               ldata[i] = ldata[i] + 1'b1;
            end
         end
         apply_lanes();
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (!(src_valid[i] && !acc[i])) begin
               src_valid[i]       = $urandom_range(0, 2) != 0;
               src_last[i]        = $urandom_range(0, 2) == 0;
               src_data[i*W +: W] = W'($urandom);
               src_dest[2*i +: 2] = 2'($urandom);
            end
         end
         dst_ready = 4'($urandom) | 4'($urandom);
      end
   endtask

   task automatic step();
      @(negedge clk);
      acc = src_valid & src_ready;
      if (acc != 4'b0) dut_beats.push_back(int'(mux_sel));
      model_cycle();
      @(posedge clk);
      #1;
      next_inputs();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_src_ready"}, src_ready, 4'b0);
      chk({name, "_dst_valid"}, dst_valid, 4'b0);
      chk({name, "_mux_sel"}, mux_sel, 2'd0);
      chk({name, "_demux_sel"}, demux_sel, 2'd0);
      chk({name, "_dst_data"}, dst_data, 16'h0);
      chk({name, "_busy"}, busy, 1'b0);
   endtask

   initial begin
      int rr_exp[5];
      int bl_exp[9];
      rr_exp = '{0, 1, 2, 3, 0};
      bl_exp = '{1, 1, 1, 1, 3, 1, 1, 1, 1};
      acc = '0;
      model_reset();
      rst       = 1'b0;
      dst_ready = 4'hF;
      for (int i = 0; i < 4; i++) begin
         rem[i]   = 100;
         lastv[i] = 1'b1;
         ldest[i] = 2'(i);
         ldata[i] = 16'hA000 + 16'(i * 16'h100);
      end
      apply_lanes();
      #1;
      chk_zero("reset");
      steps(2);
      chk_zero("reset_held");
      rst = 1'b1;

      // Reset release and round robin with single-beat bursts.
      dut_beats.delete();
      step();
      chk("first_grant_ready", src_ready, 4'b0001);
      chk("first_grant_sel", mux_sel, 2'd0);
      step();
      chk("first_beat_valid", dst_valid, 4'b0001);
      chk("first_beat_data", dst_data, 16'hA000);
      steps(8);
      chk("rr_count", dut_beats.size(), 5);
      for (int i = 0; i < dut_beats.size() && i < 5; i++) chk("rr_order", dut_beats[i], rr_exp[i]);

      // Single lane, one beat; then rr_ptr must favour lane 3 over lane 0.
      for (int i = 0; i < 4; i++) rem[i] = 0;
      apply_lanes();
      steps(3);
      rem[2] = 1; ldata[2] = 16'h1248; ldest[2] = 2'd3;
      apply_lanes();
      step();
      chk("single_sel", mux_sel, 2'd2);
      chk("single_ready", src_ready, 4'b0100);
      rem[0] = 1; rem[3] = 1;
      apply_lanes();
      step();
      chk("single_valid", dst_valid, 4'b1000);
      chk("single_data", dst_data, 16'h1248);
      chk("single_demux", demux_sel, 2'd3);
      step();
      chk("ptr_after_single", mux_sel, 2'd3);
      steps(5);

      // Burst limit: lane 1 eight beats without last, lane 3 one beat.
      dut_beats.delete();
      rem[1] = 8; lastv[1] = 1'b0; rem[3] = 1;
      apply_lanes();
      steps(15);
      chk("burst_count", dut_beats.size(), 9);
      for (int i = 0; i < dut_beats.size() && i < 9; i++) chk("burst_order", dut_beats[i], bl_exp[i]);
      lastv[1] = 1'b1;

      // Backpressure on destination 0.
      rem[0] = 4; lastv[0] = 1'b0; ldest[0] = 2'd0; ldata[0] = 16'h0B00;
      dst_ready = 4'b1110;
      apply_lanes();
      steps(2);
      for (int i = 0; i < 3; i++) begin
         chk("bp_ready", src_ready, 4'b0000);
         chk("bp_data", dst_data, 16'h0B00);
         chk("bp_valid", dst_valid, 4'b0001);
         step();
      end
      dst_ready = 4'hF;
      #1;
      chk("bp_release_ready", src_ready, 4'b0001);
      step();
      chk("bp_next_valid", dst_valid, 4'b0001);
      chk("bp_next_data", dst_data, 16'h0B01);
      steps(4);
      lastv[0] = 1'b1;

      // Asynchronous reset in the middle of a burst.
      rem[2] = 4; lastv[2] = 1'b0; ldata[2] = 16'hC000;
      apply_lanes();
      steps(2);
      chk("mid_busy", busy, 1'b1);
      #1;
      rst = 1'b0;
      model_reset();
      #1;
      chk_zero("async");
      for (int i = 0; i < 4; i++) rem[i] = 0;
      rem[1] = 1; rem[3] = 1; lastv[2] = 1'b1;
      apply_lanes();
      #1;
      rst = 1'b1;
      step();
      chk("restart_sel", mux_sel, 2'd1);
      chk("restart_ready", src_ready, 4'b0010);
      chk("restart_no_stale", dst_valid, 4'b0000);
      steps(5);

      // Randomized traffic.
      rand_mode = 1'b1;
      steps(3000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mux_demux_rr_scheduler.md
Name: mux_demux_rr_scheduler

Overview:
- Sequences the shared 4:1 mux -> 1:4 demux datapath, replacing the free-running counter that currently drives sel.
- Four source lanes compete for the single shared channel under round-robin arbitration with bounded bursts.
- Each beat carries its own 2-bit destination. The block drives mux_sel and demux_sel and registers the routed word toward the four destinations.
- All handshakes are valid/ready.

Parameters:
- WIDTH, 16, data width of one lane word.
- MAX_BURST, 4, maximum consecutive beats granted to one owner before forced release (legal range 1..16).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- src_valid  in  4  per-lane beat valid.
- src_ready  out  4  per-lane beat accept.
- src_data  in  4*WIDTH  lane i at [i*WIDTH +: WIDTH].
- src_dest  in  8  lane i destination at [2*i +: 2].
- src_last  in  4  lane i beat is the final beat of its burst.
- mux_sel  out  2  select for the shared mux; equals the current owner.
- demux_sel  out  2  select for the shared demux; destination of the held output beat.
- dst_valid  out  4  one-hot output valid: out_valid << demux_sel.
- dst_ready  in  4  per-destination accept.
- dst_data  out  WIDTH  registered routed word.
- busy  out  1  high when state==BURST or out_valid==1.

Behaviour:
- Reset (rst low, asynchronous) clears:
  - state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
  - mux_sel=0, demux_sel=0, out_valid=0, dst_data=0.
  - src_ready=0, dst_valid=0, busy=0.
  - A beat held in the output register is dropped.
- Output register:
  - can_load = !out_valid || dst_ready[demux_sel].
  - A beat is consumed when out_valid && dst_ready[demux_sel].
  - If consumed with no new load, out_valid clears next edge.
  - A load and a consume in the same cycle keep out_valid=1, so the output sustains 1 beat/cycle.
- State IDLE:
  - src_ready=0.
  - If any src_valid is high, the winner is the first valid lane scanning rr_ptr, rr_ptr+1, ... modulo 4.
  - At the edge: owner<=winner, beat_cnt<=0, state<=BURST.
  - No transfer occurs in the arbitration cycle (1-cycle arbitration bubble).
- State BURST:
  - mux_sel=owner. src_ready[owner]=can_load; all other src_ready=0.
  - Transfer happens when src_valid[owner] && src_ready[owner]. On a transfer:
    - dst_data <= src_data lane owner.
    - demux_sel <= src_dest lane owner.
    - out_valid <= 1, beat_cnt <= beat_cnt+1.
  - Burst ends on:
    - a transfer with src_last[owner]=1; or
    - a transfer with beat_cnt==MAX_BURST-1; or
    - src_valid[owner]==0 (owner idle, no transfer that cycle).
  - At burst end: rr_ptr <= owner+1 (wraps 3->0), state <= IDLE.
  - src_last and the MAX_BURST limit in the same beat produce a single end.
  - If can_load=0, the owner stalls in BURST. Its valid/data must stay stable; this is not a release.
- The destination may change beat-to-beat within a burst. demux_sel updates only on a load.
- Latency: source accept to dst_valid is 1 cycle. First beat of a new burst arrives 2 cycles after valid is raised in IDLE.
- Fairness: a lane waits at most 3 bursts (each ≤ MAX_BURST beats) before it is granted.
- MAX_BURST=1: every beat re-arbitrates.
- Source-lane requests that are raised or dropped outside the owner's lane have no effect during BURST.

Test Plan:
- Reset/idle: hold rst low 2 cycles with all src_valid=1 -> all outputs 0. After release: owner=0 in BURST, with first dst_valid one cycle after the first src_ready.
- Single lane, one beat: lane 2 sends 16'h1248 with dest=3, last=1 -> mux_sel=2, dst_valid=4'b1000, dst_data=16'h1248 one cycle after accept. rr_ptr then points to 3 and state returns to IDLE.
- Round robin: all four lanes valid with last=1 each beat, all dst_ready=1 -> grant order 0,1,2,3,0. Exactly one beat per grant, with a 1-cycle IDLE gap between beats.
- Burst limit: MAX_BURST=4, lane 1 valid with last=0 for 8 beats, lane 3 also valid -> lane 1 gets 4 beats, lane 3 gets its turn, then lane 1 resumes.
- Backpressure: dest 0 beat held with dst_ready[0]=0 for 3 cycles -> src_ready[owner]=0 and dst_data stable throughout. On dst_ready[0]=1, the next beat loads the same cycle and out_valid stays 1.
- Async reset mid-burst: drop rst while out_valid=1 and state=BURST -> outputs clear immediately, with no clock edge needed. The held beat is never presented, and arbitration restarts from lane 0.
